mem_wr_burst_ctrl: RTL and testbench



---
 rtl/mem_wr_burst_ctrl_if.sv | 27 ++
 rtl/mem_wr_burst_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_wr_burst_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_wr_burst_ctrl_if.sv
// Handshake bundle between the write burst master, its FWFT burst FIFO and the
// memory controller write port. The master modport is the burst controller side.
interface mem_wr_burst_ctrl_if #(
  parameter int DW = 36,
  parameter int AW = 21
);
  logic          burst_avail_i;
  logic          burst_rd_en_o;
  logic [DW-1:0] burst_rd_data_i;
  logic          cmd_vld_o;
  logic          cmd_rdy_i;
  logic [AW-1:0] cmd_addr_o;
  logic          wdata_vld_o;
  logic          wdata_rdy_i;
  logic [DW-1:0] wdata_o;
  logic          wdata_last_o;

  modport master (
    input  burst_avail_i, burst_rd_data_i, cmd_rdy_i, wdata_rdy_i,
    output burst_rd_en_o, cmd_vld_o, cmd_addr_o, wdata_vld_o, wdata_o, wdata_last_o
  );

  modport slave (
    output burst_avail_i, burst_rd_data_i, cmd_rdy_i, wdata_rdy_i,
    input  burst_rd_en_o, cmd_vld_o, cmd_addr_o, wdata_vld_o, wdata_o, wdata_last_o
  );
endinterface

// File: rtl/mem_wr_burst_ctrl.sv
// Write-path burst master: one command plus BL beats per available FIFO burst, wrapping address window.
// Optional feature macro MEM_WR_BURST_CNT_EN adds a saturating completed-burst counter burst_cnt_o.
module mem_wr_burst_ctrl #(
  parameter int DW          = 36,
  parameter int AW          = 21,
  parameter int BL          = 16,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 1048576
) (
  input  logic        rd_clk,
  input  logic        wr_rst,
  input  logic        enable_i,
  input  logic        frame_start_i,
  output logic        burst_done_o,
  output logic        busy_o,
`ifdef MEM_WR_BURST_CNT_EN
  output logic [15:0] burst_cnt_o,
`endif
  mem_wr_burst_ctrl_if.master bus
);

  localparam int                CW        = (BL > 1) ? $clog2(BL) : 1;
  localparam logic [CW-1:0]     LAST_BEAT = CW'(BL - 1);
  localparam logic [AW-1:0]     BASE_A    = AW'(BASE_ADDR);
  localparam logic [AW:0]       END_ADDR  = (AW + 1)'(BASE_ADDR + FRAME_WORDS);
  localparam logic [AW:0]       BL_STEP   = (AW + 1)'(BL);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  state_t        state_r;
  state_t        state_s;
  logic          done2_r;
  logic [CW-1:0] beat_cnt_r;
  logic [AW-1:0] addr_r;
  logic          pend_r;
  logic          beat_acc_s;
  logic          addr_upd_s;
  logic [AW:0]   addr_inc_s;

  assign beat_acc_s = (state_r == DATA) && bus.wdata_rdy_i;
  assign addr_upd_s = (state_r == DONE) && !done2_r;
  assign addr_inc_s = {1'b0, addr_r} + BL_STEP;

  // State register; done2_r marks the second of the two DONE cycles.
  always_ff @(posedge rd_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_r <= IDLE;
      done2_r <= 1'b0;
    end else begin
      state_r <= state_s;
      done2_r <= addr_upd_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable_i && bus.burst_avail_i) state_s = CMD;
        else                               state_s = IDLE;
      end
      CMD: begin
        if (bus.cmd_rdy_i) state_s = DATA;
        else               state_s = CMD;
      end
      DATA: begin
        if (beat_acc_s && (beat_cnt_r == LAST_BEAT)) state_s = DONE;
        else                                         state_s = DATA;
      end
      DONE: begin
        // burst_avail_i is ignored here: the FIFO count lags the pops by two cycles
        if (done2_r) state_s = IDLE;
        else         state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Beat counter, frame address and deferred frame-restart flag.
  always_ff @(posedge rd_clk or posedge wr_rst) begin
    if (wr_rst) begin
      beat_cnt_r <= {CW{1'b0}};
      addr_r     <= BASE_A;
      pend_r     <= 1'b0;
    end else begin
      if ((state_r == IDLE) && (state_s == CMD)) beat_cnt_r <= {CW{1'b0}};
      else if (beat_acc_s)                       beat_cnt_r <= beat_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      else                                       beat_cnt_r <= beat_cnt_r;

      if (addr_upd_s)                                  pend_r <= 1'b0;
      else if (frame_start_i && (state_r != IDLE))     pend_r <= 1'b1;
      else                                             pend_r <= pend_r;

      // A restart requested during a burst (or coinciding with its update) beats the increment
      if (addr_upd_s) begin
        if (pend_r || frame_start_i || (addr_inc_s == END_ADDR)) addr_r <= BASE_A;
        else                                                     addr_r <= addr_inc_s[AW-1:0];
      end else if (frame_start_i && (state_r == IDLE)) begin
        addr_r <= BASE_A;
      end else begin
        addr_r <= addr_r;
      end
    end
  end

`ifdef MEM_WR_BURST_CNT_EN
  logic [15:0] burst_cnt_r;

  // Saturating count of completed bursts since reset or the last frame start.
  always_ff @(posedge rd_clk or posedge wr_rst) begin
    if (wr_rst)                                    burst_cnt_r <= 16'd0;
    else if (frame_start_i)                        burst_cnt_r <= 16'd0;
    else if (addr_upd_s && (burst_cnt_r != 16'hFFFF)) burst_cnt_r <= burst_cnt_r + 16'd1;
    else                                           burst_cnt_r <= burst_cnt_r;
  end

  assign burst_cnt_o = burst_cnt_r;
`endif

  assign bus.cmd_vld_o     = (state_r == CMD);
  assign bus.cmd_addr_o    = addr_r;
  assign bus.wdata_vld_o   = (state_r == DATA);
  assign bus.wdata_last_o  = (state_r == DATA) && (beat_cnt_r == LAST_BEAT);
  assign bus.wdata_o       = (state_r == DATA) ? bus.burst_rd_data_i : {DW{1'b0}};
  assign bus.burst_rd_en_o = beat_acc_s;
  assign burst_done_o      = addr_upd_s;
  assign busy_o            = (state_r != IDLE);

endmodule

// File: tb/tb_mem_wr_burst_ctrl.sv
// Directed bench for mem_wr_burst_ctrl with BASE_ADDR=128, FRAME_WORDS=64, BL=16 (window 128..191).
module tb_mem_wr_burst_ctrl;
  localparam int DW = 36;
  localparam int AW = 21;
  localparam int BL = 16;

  logic        rd_clk = 1'b0;
  logic        wr_rst;
  logic        enable_i;
  logic        frame_start_i;
  logic        burst_done_o;
  logic        busy_o;
`ifdef MEM_WR_BURST_CNT_EN
  logic [15:0] burst_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_idx = 0;
  logic [15:0] pop_idx = 16'd0;

  mem_wr_burst_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  mem_wr_burst_ctrl #(
    .DW(DW), .AW(AW), .BL(BL), .BASE_ADDR(128), .FRAME_WORDS(64)
  ) dut (
    .rd_clk        (rd_clk),
    .wr_rst        (wr_rst),
    .enable_i      (enable_i),
    .frame_start_i (frame_start_i),
    .burst_done_o  (burst_done_o),
    .busy_o        (busy_o),
`ifdef MEM_WR_BURST_CNT_EN
    .burst_cnt_o   (burst_cnt_o),
`endif
    .bus           (bus)
  );

  always #5 rd_clk = ~rd_clk;

  // FWFT FIFO model: head word carries its pop index
  assign bus.burst_rd_data_i = {20'hC0DE5, pop_idx};
  always @(posedge rd_clk) if (bus.burst_rd_en_o) pop_idx <= pop_idx + 16'd1;

  function automatic logic [35:0] pat(input int i);
    logic [15:0] lo;
    lo = i[15:0];
    return {20'hC0DE5, lo};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge rd_clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [20:0] exp_addr);
    chk({tag, "_cmd_vld"}, bus.cmd_vld_o, 1'b0);
    chk({tag, "_wdata_vld"}, bus.wdata_vld_o, 1'b0);
    chk({tag, "_wdata_last"}, bus.wdata_last_o, 1'b0);
    chk({tag, "_rd_en"}, bus.burst_rd_en_o, 1'b0);
    chk({tag, "_wdata"}, bus.wdata_o, 36'h0);
    chk({tag, "_done"}, burst_done_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_addr"}, bus.cmd_addr_o, exp_addr);
  endtask

  // Runs one burst from IDLE; ends in IDLE unless rst_beat fires (then returns with wr_rst high).
  task automatic do_burst(input logic [20:0] exp_addr, input int cmd_stall, input bit toggle,
                          input bit en_drop, input int fs_beat, input int rst_beat);
    int beat;
    int cyc;
    enable_i = 1'b1;
    bus.burst_avail_i = 1'b1;
    bus.cmd_rdy_i = (cmd_stall == 0);
    bus.wdata_rdy_i = 1'b0;
    tick;
    bus.burst_avail_i = 1'b0;
    if (en_drop) enable_i = 1'b0;
    chk("cmd_vld", bus.cmd_vld_o, 1'b1);
    chk("cmd_addr", bus.cmd_addr_o, exp_addr);
    chk("cmd_busy", busy_o, 1'b1);
    for (int i = 0; i < cmd_stall; i++) begin
      tick;
      chk("cmd_hold_vld", bus.cmd_vld_o, 1'b1);
      chk("cmd_hold_addr", bus.cmd_addr_o, exp_addr);
    end
    bus.cmd_rdy_i = 1'b1;
    tick;
    bus.cmd_rdy_i = 1'b0;
    beat = 0;
    cyc = 0;
    while (beat < BL && cyc < 100) begin
      if (beat == rst_beat) begin
        wr_rst = 1'b1;
        bus.wdata_rdy_i = 1'b1;
        #1;
        chk_idle_outputs("rst_mid", 21'd128);
        return;
      end
      bus.wdata_rdy_i = toggle ? ((cyc % 2) == 0) : 1'b1;
      frame_start_i = (beat == fs_beat) && bus.wdata_rdy_i;
      #1;
      chk("data_vld", bus.wdata_vld_o, 1'b1);
      chk("data_last", bus.wdata_last_o, beat == BL - 1);
      chk("rd_en", bus.burst_rd_en_o, bus.wdata_rdy_i);
      chk("data_cmd_vld", bus.cmd_vld_o, 1'b0);
      if (bus.wdata_rdy_i) chk("wdata", bus.wdata_o, pat(exp_idx));
      tick;
      frame_start_i = 1'b0;
      if (bus.wdata_rdy_i) begin
        beat++;
        exp_idx++;
      end
      cyc++;
    end
    bus.wdata_rdy_i = 1'b0;
    chk("data_beats", beat, BL);
    chk("done1_pulse", burst_done_o, 1'b1);
    chk("done1_vld", bus.wdata_vld_o, 1'b0);
    chk("done1_busy", busy_o, 1'b1);
    tick;
    chk("done2_pulse", burst_done_o, 1'b0);
    chk("done2_busy", busy_o, 1'b1);
    tick;
    chk("idle_busy", busy_o, 1'b0);
    chk("fifo_pops", pop_idx, exp_idx[15:0]);
  endtask

  initial begin
    wr_rst = 1'b1;
    enable_i = 1'b0;
    frame_start_i = 1'b0;
    bus.burst_avail_i = 1'b0;
    bus.cmd_rdy_i = 1'b0;
    bus.wdata_rdy_i = 1'b0;
    tick;
    tick;
    chk_idle_outputs("reset", 21'd128);
    wr_rst = 1'b0;

    // enable low blocks a start even with a burst available
    bus.burst_avail_i = 1'b1;
    tick;
    tick;
    chk("en_gate_busy", busy_o, 1'b0);
    chk("en_gate_cmd", bus.cmd_vld_o, 1'b0);

    do_burst(21'd128, 0, 1'b0, 1'b0, -1, -1);
    chk("addr_after_A", bus.cmd_addr_o, 21'd144);
    do_burst(21'd144, 5, 1'b1, 1'b1, -1, -1);
    chk("addr_after_B", bus.cmd_addr_o, 21'd160);
    bus.burst_avail_i = 1'b1;
    tick;
    tick;
    chk("en_drop_busy", busy_o, 1'b0);
    do_burst(21'd160, 0, 1'b0, 1'b0, -1, -1);
    do_burst(21'd176, 0, 1'b0, 1'b0, -1, -1);
    chk("addr_wrap", bus.cmd_addr_o, 21'd128);
    do_burst(21'd128, 0, 1'b0, 1'b0, -1, -1);
    do_burst(21'd144, 0, 1'b1, 1'b0, 5, -1);
    chk("addr_fs_data", bus.cmd_addr_o, 21'd128);
    do_burst(21'd128, 0, 1'b0, 1'b0, -1, -1);
    chk("addr_after_H", bus.cmd_addr_o, 21'd144);

    frame_start_i = 1'b1;
    tick;
    frame_start_i = 1'b0;
    chk("addr_fs_idle", bus.cmd_addr_o, 21'd128);

    do_burst(21'd128, 0, 1'b0, 1'b0, -1, 6);
    bus.wdata_rdy_i = 1'b0;
    tick;
    tick;
    chk_idle_outputs("rst_hold", 21'd128);
    wr_rst = 1'b0;
    chk("rst_no_pop", pop_idx, exp_idx[15:0]);

    do_burst(21'd128, 0, 1'b0, 1'b0, -1, -1);
    do_burst(21'd144, 0, 1'b0, 1'b0, -1, -1);
    do_burst(21'd160, 0, 1'b0, 1'b0, -1, -1);
    chk("addr_after_K", bus.cmd_addr_o, 21'd176);
`ifdef MEM_WR_BURST_CNT_EN
    chk("burst_cnt_3", burst_cnt_o, 16'd3);
`endif
    frame_start_i = 1'b1;
    tick;
    frame_start_i = 1'b0;
    chk("addr_fs_final", bus.cmd_addr_o, 21'd128);
`ifdef MEM_WR_BURST_CNT_EN
    chk("burst_cnt_clr", burst_cnt_o, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
